// File: rtl/mem_port_arbiter_if.sv
// Bundle for the shared memory port: fetch/data requester handshakes plus the memory bus.
// Latency: none; this is wiring only.
// Backpressure: requesters hold *_req until the matching *_gnt pulse.
// Ports: if_* is the fetch requester, dm_* is the data requester, mem_* is the memory side, busy is status.
// Modports: slave is the arbiter view; master is the combined requester/memory view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // fetch requester
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    // data requester
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    // status
    logic          busy;
    // memory port
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output busy,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  busy,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data accesses onto one single-ported memory.
// Latency: req sampled in IDLE at T -> gnt/mem_en at T+1 -> rvalid at T+2+MEM_LAT.
// Backpressure: one transaction in flight; requests are only sampled in IDLE, losers keep req held.
// Ports: clk, reset (synchronous, active-high), bus (mem_port_arbiter_if.slave: requesters + memory).
// Parameters: AW/DW address/data width, MEM_LAT issue-to-rdata latency (1..7).
// Option: define ARB_ROUND_ROBIN_EN to break ties against the previous owner instead of DM-first.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_port_arbiter_if.slave      bus
);

    localparam int CNT_W = 3;  // holds MEM_LAT up to 7

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               we_q, we_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      if_rdata_q, if_rdata_d;
    logic [DW-1:0]      dm_rdata_q, dm_rdata_d;
    logic               any_req;
    logic               pick_dm;

    assign any_req = bus.if_req | bus.dm_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;

    // On a tie the requester that did not own the previous transaction wins.
    always_comb begin
        if (bus.dm_req && bus.if_req) begin
            pick_dm = (last_owner_q == OWN_IF);
        end else begin
            pick_dm = bus.dm_req;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == S_ISSUE) begin
            last_owner_d = owner_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_q <= OWN_IF;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    // Data access belongs to the instruction already in flight, so it wins every tie.
    always_comb begin
        pick_dm = bus.dm_req;
    end
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (any_req) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (cnt_q == CNT_W'(1)) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- transaction datapath ----------------
    always_comb begin
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d = pick_dm ? OWN_DM : OWN_IF;
                    if (pick_dm) begin
                        we_d    = bus.dm_we;
                        addr_d  = bus.dm_addr;
                        wdata_d = bus.dm_wdata;
                    end else begin
                        // fetches carry no write data; the memory bus keeps the last value
                        we_d    = 1'b0;
                        addr_d  = bus.if_addr;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d = CNT_W'(MEM_LAT);
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // counter==1 is exactly MEM_LAT cycles after the issue cycle
                if (cnt_q == CNT_W'(1) && !we_q) begin
                    if (owner_q == OWN_DM) begin
                        dm_rdata_d = bus.mem_rdata;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // ---------------- outputs (decoded from registered state) ----------------
    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.mem_en    = (state_q == S_ISSUE);
        bus.mem_we    = (state_q == S_ISSUE) && we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.if_gnt    = (state_q == S_ISSUE) && (owner_q == OWN_IF);
        bus.dm_gnt    = (state_q == S_ISSUE) && (owner_q == OWN_DM);
        bus.if_rvalid = (state_q == S_RESP)  && (owner_q == OWN_IF);
        bus.dm_rvalid = (state_q == S_RESP)  && (owner_q == OWN_DM);
        bus.if_rdata  = if_rdata_q;
        bus.dm_rdata  = dm_rdata_q;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequenced arbiter that shares the single-ported unified memory between the instruction-fetch requester (FX state of the multicycle controller) and the data requester (LB/SB states). It accepts one transaction at a time, drives the memory port for exactly one issue cycle, waits a fixed memory latency, and returns a single-cycle response pulse to the winning requester. It sits between the controller/datapath and the memory model.

## Interface
- `AW`, default 32, address width.
- `DW`, default 32, data width.
- `MEM_LAT`, default 1, cycles from issue to `mem_rdata` valid; legal range 1..7.

Ports:
- `clk` in 1: clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request; held until `if_gnt`.
- `if_addr` in AW: fetch address.
- `if_gnt` out 1: one-cycle pulse; fetch request accepted.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` valid.
- `if_rdata` out DW: registered fetch data.
- `dm_req` in 1: data request; held until `dm_gnt`.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_addr` in AW: data address.
- `dm_wdata` in DW: store data.
- `dm_gnt` out 1: one-cycle pulse; data request accepted.
- `dm_rvalid` out 1: one-cycle pulse; load data valid or store complete.
- `dm_rdata` out DW: registered load data.
- `busy` out 1: high in every state except IDLE.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data, valid `MEM_LAT` cycles after the `mem_en` cycle.

## Operation
- **FSM states**: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from registered state.
- **IDLE**
  - Requests are sampled only in IDLE.
  - If either request is high, pick the winner, latch owner, address, we and wdata, and go to ISSUE.
  - If neither request is high, stay in IDLE.
- **Arbitration (default)**: fixed priority, DM over IF. The data access belongs to the instruction already in flight.
- **ISSUE (1 cycle)**
  - `mem_en`=1; `mem_we`/`mem_addr`/`mem_wdata` come from the latched values.
  - The owner's `gnt`=1.
  - Load the latency counter with `MEM_LAT`, then go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - On the cycle the counter equals 1: capture `mem_rdata` into the owner's rdata register (loads and fetches only), then go to RESP.
  - Stores leave both rdata registers unchanged.
- **RESP (1 cycle)**: the owner's `rvalid`=1, then go to IDLE.
- **Memory port outside ISSUE**: `mem_en` and `mem_we` are 0. `mem_addr`/`mem_wdata` hold their last latched value.
- **Request release**: requesters deassert `req` after `gnt`. A `req` still high when the FSM returns to IDLE is a new request.
- **Request changes**: changes to `req`/addr/data after ISSUE have no effect on the transaction in flight.
- **Reset values**: state=IDLE, every output 0, `if_rdata`=`dm_rdata`=0, `last_owner`=IF.
- **Reset mid-transaction**: the transaction is abandoned; no `rvalid`/`gnt` is issued and `mem_en`=0 from the next cycle.

## Timing
- **Request to grant**: `req` sampled high in IDLE at cycle T, then `gnt` and `mem_en` in cycle T+1.
- **Data capture**: `mem_rdata` is captured at the end of cycle T+1+`MEM_LAT`.
- **Response**: `rvalid` in cycle T+2+`MEM_LAT`, with rdata valid in the same cycle; rdata is held until the next capture.
- **Back-to-back**: the earliest next `gnt` is cycle T+4+`MEM_LAT`, since one IDLE cycle always separates transactions.
- **Simultaneous requests**: the loser keeps `req` high and is granted on the next IDLE.
- **Exclusivity**: exactly one of `if_gnt`/`dm_gnt` is high in ISSUE, and never both `rvalid`s.

## Configuration
- **`ARB_ROUND_ROBIN_EN` undefined**: fixed priority, DM wins every tie.
- **`ARB_ROUND_ROBIN_EN` defined**:
  - On a tie, the requester not equal to `last_owner` wins.
  - `last_owner` updates in ISSUE and resets to IF, so the first tie goes to DM.
  - Single-requester behaviour is unchanged.

## Test plan
- **Single fetch, `MEM_LAT`=1**: `if_req`, `if_addr`=0x40, memory word 0x8C010004 → `if_gnt` at T+1 with `mem_addr`=0x40, `mem_we`=0; `if_rvalid`=1 at T+3 with `if_rdata`=0x8C010004.
- **Store then load, `MEM_LAT`=3**: `dm_we`=1, addr 0x100, wdata 0xA5 → `mem_we`=1 for exactly one cycle and `dm_rvalid` at T+5. Then load 0x100 → `dm_rdata`=0xA5.
- **Tie**: `if_req` and `dm_req` high in the same IDLE cycle.
  - Default build: `dm_gnt` first, `if_gnt` at T+5 (`MEM_LAT`=1).
  - With `ARB_ROUND_ROBIN_EN`: alternating grants over 4 held ties, DM, IF, DM, IF.
- **Reset in WAIT**: `reset` during WAIT → no `rvalid`, all outputs 0 next cycle, and a new `if_req` is served normally afterwards.
- **Request glitch**: `dm_req` pulsed for one cycle during a fetch's WAIT and gone by IDLE → no `dm_gnt`, `busy`=0 after RESP.
